// File: rtl/seq_bus_datapath.sv
// Single-bus register-transfer datapath with a built-in microsequencer.
// Each accepted command steps through T_A (Ra->Y), T_B (Y op Rb -> Z), T_W (Z or short-op source -> dest).
module seq_bus_datapath #(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REGS = 16,
  parameter  bit ZERO_R0  = 1'b1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [WIDTH-1:0] inport_data,
  output logic [WIDTH-1:0] outport_output,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] bus_contents,
  output logic             done,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, T_A, T_B, T_W} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_SHL  = 4'd4,  OP_SHR  = 4'd5,  OP_SRA  = 4'd6,  OP_MUL  = 4'd7,
    OP_MOVI = 4'd8,  OP_IN   = 4'd9,  OP_OUT  = 4'd10, OP_MFHI = 4'd11,
    OP_MFLO = 4'd12
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [AW-1:0]    rd_q, ra_q, rb_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] y, z_hi, z_lo, hi, lo, outport;
  logic [WIDTH-1:0] bus, ra_val, rb_val, alu_hi, alu_lo;
  logic [2*WIDTH-1:0] prod;

  logic cmd_short, cmd_illegal;

  assign cmd_short      = (cmd_op >= 4'd8) && (cmd_op <= 4'd12);
  assign cmd_illegal    = (cmd_op >= 4'd13);
  assign cmd_ready      = (state == IDLE);
  assign outport_output = outport;
  assign hi_out         = hi;
  assign lo_out         = lo;
  assign bus_contents   = bus;

  always_comb begin
    ra_val = regs[ra_q];
    rb_val = regs[rb_q];
    if (ZERO_R0 && ra_q == '0) ra_val = '0;
    if (ZERO_R0 && rb_q == '0) rb_val = '0;
  end

  always_comb begin
    bus = '0;
    case (state)
      T_A: bus = ra_val;
      T_B: bus = rb_val;
      T_W: begin
        case (op_q)
          OP_MOVI: bus = imm_q;
          OP_IN:   bus = inport_data;
          OP_OUT:  bus = ra_val;
          OP_MFHI: bus = hi;
          OP_MFLO: bus = lo;
          default: bus = z_lo;
        endcase
      end
      default: bus = '0;
    endcase
  end

  // ALU sees Y as operand A and the bus (Rb in T_B) as operand B.
  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    prod   = '0;
    case (op_q)
      OP_ADD: alu_lo = y + bus;
      OP_SUB: alu_lo = y - bus;
      OP_AND: alu_lo = y & bus;
      OP_OR:  alu_lo = y | bus;
      OP_SHL: alu_lo = y << bus[SW-1:0];
      OP_SHR: alu_lo = y >> bus[SW-1:0];
      OP_SRA: alu_lo = $signed(y) >>> bus[SW-1:0];
      OP_MUL: begin
        prod   = $signed({{WIDTH{y[WIDTH-1]}}, y}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});
        alu_hi = prod[2*WIDTH-1:WIDTH];
        alu_lo = prod[WIDTH-1:0];
      end
      default: alu_lo = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
      op_q    <= OP_ADD;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
      y       <= '0;
      z_hi    <= '0;
      z_lo    <= '0;
      hi      <= '0;
      lo      <= '0;
      outport <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= op_t'(cmd_op);
            rd_q  <= cmd_rd;
            ra_q  <= cmd_ra;
            rb_q  <= cmd_rb;
            imm_q <= cmd_imm;
            if (cmd_illegal) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (cmd_short) begin
              state <= T_W;
            end else begin
              state <= T_A;
            end
          end
        end
        T_A: begin
          y     <= bus;
          state <= T_B;
        end
        T_B: begin
          z_hi  <= alu_hi;
          z_lo  <= alu_lo;
          state <= T_W;
        end
        T_W: begin
          done  <= 1'b1;
          state <= IDLE;
          case (op_q)
            OP_OUT: outport <= bus;
            OP_MUL: begin
              hi <= z_hi;
              lo <= z_lo;
            end
            default: begin
              if (!(ZERO_R0 && rd_q == '0)) regs[rd_q] <= bus;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bus_datapath.sv
// Scoreboard bench for seq_bus_datapath: a reference model predicts each command's
// latency, err flag, bus activity and visible registers; results are compared on done.
module tb_seq_bus_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_rd, cmd_ra, cmd_rb;
  logic [31:0] cmd_imm;
  logic [31:0] inport_data;
  logic [31:0] outport_output, hi_out, lo_out, bus_contents;
  logic        done, err;

  seq_bus_datapath #(.WIDTH(32), .NUM_REGS(16), .ZERO_R0(1'b1)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .inport_data(inport_data),
    .outport_output(outport_output), .hi_out(hi_out), .lo_out(lo_out),
    .bus_contents(bus_contents), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          nbus;
    logic        err;
    logic [31:0] out, hi, lo, b0, b1, b2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [16];
  logic [31:0] mhi, mlo, mout;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mhi = '0; mlo = '0; mout = '0;
  endtask

  task automatic model_cmd(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [31:0] imm, input logic [31:0] inp,
                           output exp_t e);
    logic [31:0] a, b, v;
    logic [4:0]  sh;
    longint      sa, sbv, p;
    a = (ra == 0) ? 32'h0 : mregs[ra];
    b = (rb == 0) ? 32'h0 : mregs[rb];
    sh = b[4:0];
    v = '0;
    e.lat = 0; e.nbus = 0; e.err = 1'b0;
    e.b0 = '0; e.b1 = '0; e.b2 = '0;
    if (op <= 4'd7) begin
      case (op)
        4'd0: v = a + b;
        4'd1: v = a - b;
        4'd2: v = a & b;
        4'd3: v = a | b;
        4'd4: v = a << sh;
        4'd5: v = a >> sh;
        4'd6: v = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        default: begin
          sa = $signed(a);
          sbv = $signed(b);
          p = sa * sbv;
          mhi = p[63:32];
          mlo = p[31:0];
          v = p[31:0];
        end
      endcase
      e.lat = 3; e.nbus = 3; e.b0 = a; e.b1 = b; e.b2 = v;
      if (op != 4'd7 && rd != 0) mregs[rd] = v;
    end else if (op <= 4'd12) begin
      case (op)
        4'd8:  v = imm;
        4'd9:  v = inp;
        4'd10: v = a;
        4'd11: v = mhi;
        default: v = mlo;
      endcase
      e.lat = 1; e.nbus = 1; e.b0 = v;
      if (op == 4'd10) mout = v;
      else if (rd != 0) mregs[rd] = v;
    end else begin
      e.err = 1'b1;
    end
    e.out = mout; e.hi = mhi; e.lo = mlo;
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that shows done.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [31:0] imm);
    exp_t        e;
    logic [31:0] bs [4];
    int          n;
    model_cmd(op, rd, ra, rb, imm, inport_data, e);
    sb.push_back(e);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    cmd_valid = 1'b1;
    check("ready_before", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) bs[k] = '0;
    while (!done && n < 10) begin
      if (n < 4) bs[n] = bus_contents;
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    if (!done) begin
      check($sformatf("done_timeout op%0d", op), 32'(n), 32'(e.lat));
    end else begin
      check($sformatf("latency op%0d", op), 32'(n), 32'(e.lat));
      check($sformatf("err op%0d", op), 32'(err), 32'(e.err));
      check("ready_at_done", 32'(cmd_ready), 32'd1);
      check("bus_idle", bus_contents, 32'h0);
      check($sformatf("outport op%0d", op), outport_output, e.out);
      check($sformatf("hi op%0d", op), hi_out, e.hi);
      check($sformatf("lo op%0d", op), lo_out, e.lo);
      if (e.nbus > 0) check($sformatf("bus0 op%0d", op), bs[0], e.b0);
      if (e.nbus > 1) check($sformatf("bus1 op%0d", op), bs[1], e.b1);
      if (e.nbus > 2) check($sformatf("bus2 op%0d", op), bs[2], e.b2);
    end
  endtask

  initial begin
    clr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_imm = '0; inport_data = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0;
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_bus", bus_contents, 32'h0);
    check("rst_hi", hi_out, 32'h0);
    check("rst_lo", lo_out, 32'h0);
    check("rst_out", outport_output, 32'h0);

    issue(4'd8, 4'd1, 4'd0, 4'd0, 32'd5);
    issue(4'd8, 4'd2, 4'd0, 4'd0, 32'd3);
    issue(4'd0, 4'd3, 4'd1, 4'd2, 32'd0);
    issue(4'd10, 4'd0, 4'd3, 4'd0, 32'd0);
    check("add_r3", outport_output, 32'd8);

    issue(4'd8, 4'd1, 4'd0, 4'd0, 32'd3);
    issue(4'd8, 4'd2, 4'd0, 4'd0, 32'd5);
    issue(4'd1, 4'd3, 4'd1, 4'd2, 32'd0);
    issue(4'd10, 4'd0, 4'd3, 4'd0, 32'd0);
    check("sub_wrap", outport_output, 32'hFFFF_FFFE);

    issue(4'd8, 4'd1, 4'd0, 4'd0, 32'd1);
    issue(4'd8, 4'd2, 4'd0, 4'd0, 32'd36);
    issue(4'd4, 4'd3, 4'd1, 4'd2, 32'd0);
    issue(4'd10, 4'd0, 4'd3, 4'd0, 32'd0);
    check("shl_mod", outport_output, 32'h10);

    issue(4'd8, 4'd1, 4'd0, 4'd0, 32'h8000_0000);
    issue(4'd8, 4'd2, 4'd0, 4'd0, 32'd4);
    issue(4'd6, 4'd3, 4'd1, 4'd2, 32'd0);
    issue(4'd10, 4'd0, 4'd3, 4'd0, 32'd0);
    check("sra", outport_output, 32'hF800_0000);
    issue(4'd5, 4'd7, 4'd1, 4'd2, 32'd0);
    issue(4'd10, 4'd0, 4'd7, 4'd0, 32'd0);
    check("shr", outport_output, 32'h0800_0000);

    issue(4'd8, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF);
    issue(4'd8, 4'd2, 4'd0, 4'd0, 32'd7);
    issue(4'd8, 4'd3, 4'd0, 4'd0, 32'h55);
    issue(4'd7, 4'd3, 4'd1, 4'd2, 32'd0);
    check("mul_hi", hi_out, 32'hFFFF_FFFF);
    check("mul_lo", lo_out, 32'hFFFF_FFF9);
    issue(4'd10, 4'd0, 4'd3, 4'd0, 32'd0);
    check("mul_rd_kept", outport_output, 32'h55);
    issue(4'd11, 4'd4, 4'd0, 4'd0, 32'd0);
    issue(4'd10, 4'd0, 4'd4, 4'd0, 32'd0);
    check("mfhi", outport_output, 32'hFFFF_FFFF);

    issue(4'd8, 4'd0, 4'd0, 4'd0, 32'hAA);
    issue(4'd10, 4'd0, 4'd0, 4'd0, 32'd0);
    check("r0_zero", outport_output, 32'h0);
    issue(4'd0, 4'd5, 4'd0, 4'd1, 32'd0);
    issue(4'd10, 4'd0, 4'd5, 4'd0, 32'd0);
    check("r0_add", outport_output, 32'hFFFF_FFFF);

    issue(4'd8, 4'd9, 4'd0, 4'd0, 32'd6);
    issue(4'd0, 4'd9, 4'd9, 4'd9, 32'd0);
    issue(4'd10, 4'd0, 4'd9, 4'd0, 32'd0);
    check("alias", outport_output, 32'd12);

    inport_data = 32'h1234;
    issue(4'd9, 4'd6, 4'd0, 4'd0, 32'd0);
    issue(4'd10, 4'd0, 4'd6, 4'd0, 32'd0);
    check("in_out", outport_output, 32'h1234);
    issue(4'd14, 4'd6, 4'd6, 4'd6, 32'hDEAD);
    issue(4'd10, 4'd0, 4'd6, 4'd0, 32'd0);
    check("illegal_nochg", outport_output, 32'h1234);

    for (int i = 0; i < 30; i++) begin
      inport_data = $urandom;
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), $urandom);
    end
    for (int r = 0; r < 8; r++) issue(4'd10, 4'd0, 4'(r), 4'd0, 32'd0);

    issue(4'd8, 4'd1, 4'd0, 4'd0, 32'd9);
    issue(4'd8, 4'd2, 4'd0, 4'd0, 32'd1);
    cmd_op = 4'd0; cmd_rd = 4'd3; cmd_ra = 4'd1; cmd_rb = 4'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("abort_ta_bus", bus_contents, 32'd9);
    @(posedge clk); #1;
    check("abort_tb_bus", bus_contents, 32'd1);
    cmd_op = 4'd8; cmd_rd = 4'd10; cmd_imm = 32'h77; cmd_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_bus", bus_contents, 32'h0);
    check("abort_hi", hi_out, 32'h0);
    check("abort_lo", lo_out, 32'h0);
    check("abort_out", outport_output, 32'h0);
    model_reset();
    clr = 1'b0;
    issue(4'd8, 4'd10, 4'd0, 4'd0, 32'h77);
    issue(4'd10, 4'd0, 4'd3, 4'd0, 32'd0);
    check("abort_no_write", outport_output, 32'h0);
    issue(4'd10, 4'd0, 4'd1, 4'd0, 32'd0);
    check("abort_r1_clear", outport_output, 32'h0);
    issue(4'd10, 4'd0, 4'd10, 4'd0, 32'd0);
    check("reissue_r10", outport_output, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bus_datapath.md
Name: seq_bus_datapath

Overview:
- Parametrised single-bus register-transfer datapath: register file, Y and Z (high/low) staging registers, HI/LO, input and output ports, and an ALU.
- A built-in microsequencer steps each accepted command through bus transfers: T_A (Ra to Y), T_B (Y op Rb to Z), T_W (Z to Rd or HI/LO).
- It is the next-generation datapath core. It generalises width and register count, and adds command handshaking, multi-cycle sequencing and an R0-hardwired-zero mode.

Parameters:
- WIDTH, 32, data/bus width in bits (must be at least 8).
- NUM_REGS, 16, number of general registers (power of two, at least 2). AW = clog2(NUM_REGS) is a derived localparam.
- ZERO_R0, 1: R0 reads as 0 and writes to it are discarded. When 0, R0 is an ordinary register.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  datapath can accept a command.
- cmd_op  in  4  opcode, see Behaviour.
- cmd_rd  in  AW  destination register.
- cmd_ra  in  AW  source A register.
- cmd_rb  in  AW  source B register.
- cmd_imm  in  WIDTH  immediate, used by MOVI.
- inport_data  in  WIDTH  external input port value.
- outport_output  out  WIDTH  output port register.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.
- bus_contents  out  WIDTH  current bus value (observability).
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-op pulse, coincident with done.

Behaviour:
- Reset: on a clk edge with clr=1, all registers, Y, Z, HI, LO and outport_output are cleared to 0; the state goes to IDLE; done=0 and err=0.
  - clr mid-command aborts the command; no write occurs.
  - clr has priority over every other event.
- States: IDLE, T_A, T_B, T_W.
  - cmd_ready=1 only in IDLE.
  - A command is accepted on an edge where cmd_valid && cmd_ready. The op and all fields are latched at that edge.
  - Inputs are ignored outside IDLE.
- Opcodes:
  - ALU ops: 0 ADD, 1 SUB (Ra−Rb), 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 SRA (arithmetic), 7 MUL (signed, 2·WIDTH-bit product).
  - Short ops: 8 MOVI (Rd<=imm), 9 IN (Rd<=inport_data), 10 OUT (outport_output<=Ra), 11 MFHI (Rd<=HI), 12 MFLO (Rd<=LO).
  - 13–15 are illegal.
- ALU op sequence, accepted at edge 0:
  - T_A in cycle 1: bus=Ra; Y<=bus.
  - T_B in cycle 2: bus=Rb; Z<=Y op bus.
  - T_W in cycle 3: bus=Zlow; Rd<=bus. For MUL instead: HI<=Zhigh, LO<=Zlow, and no Rd write.
  - done=1 in cycle 4 (registered), concurrent with cmd_ready=1. A back-to-back command may be accepted at the end of cycle 4.
- Short op sequence: IDLE→T_W directly.
  - bus carries imm, inport_data, Ra, HI or LO respectively.
  - Write at the end of cycle 1; done in cycle 2.
- Illegal op: IDLE→IDLE. No state change except done=1 and err=1 in the next cycle.
- Arithmetic and width rules:
  - ADD and SUB wrap modulo 2^WIDTH.
  - Zhigh=0 for every non-MUL op.
  - Shift amount = Rb[clog2(WIDTH)-1:0]. SRA replicates bit WIDTH-1.
- bus_contents is 0 in IDLE and is combinational from state and the latched fields.
- With ZERO_R0=1, any read of R0 drives 0, and a write with Rd=0 still completes (done pulses) but leaves R0 unchanged.
- Ra=Rb=Rd aliasing: operands are captured in Y and Z before the write, so the result uses the old values.
- HI and LO change only on MUL and on clr.

Test Plan:
- Reset, then MOVI R1=5 and MOVI R2=3, then ADD R3=R1+R2.
  - done in cycle 4 after accept; R3=8.
  - Observe bus_contents = 5, 3, 8 in T_A, T_B, T_W.
- SUB with R1=3, R2=5 → R3=0xFFFFFFFE. SHL by R2=36 → shift by 4. SRA of 0x80000000 by 4 → 0xF8000000.
- MUL with R1=0xFFFFFFFF (−1) and R2=7: HI=0xFFFFFFFF, LO=0xFFFFFFF9, Rd unchanged. Then MFHI R4 → R4=0xFFFFFFFF.
- With ZERO_R0=1: MOVI R0=0xAA gives done=1 and R0 reads 0. ADD R5=R0+R1 gives R5=R1.
- IN R6 with inport_data=0x1234, then OUT R6 → outport_output=0x1234. Opcode 14 → done=1 and err=1, no register change.
- Assert clr during the T_B of an ADD: all registers=0, state IDLE, no done. Re-issue a command with cmd_valid held high → accepted the cycle after reset deasserts.
